// File: rtl/pcileech_mux_pkg.sv
// Frame layout shared by the pcileech packer and unpacker: one status word
// holding seven slot nibbles plus a marker, followed by seven 32-bit data words.
package pcileech_mux_pkg;

   localparam logic [3:0] MUX_MARKER      = 4'hE;
   localparam logic [3:0] MUX_IDLE_NIBBLE = 4'hF;
   localparam int         MUX_SLOTS       = 7;

   typedef logic [255:0] mux_frame_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_DRAIN = 1'b1
   } demux_state_t;

   function automatic logic [3:0] frame_marker(input mux_frame_t frame);
      return frame[231:228];
   endfunction

   // Slot nibbles are interleaved around the marker, odd slots in the upper half of each byte.
   function automatic logic [3:0] slot_nibble(input mux_frame_t frame, input logic [2:0] i);
      case (i)
         3'd0:    return frame[251:248];
         3'd1:    return frame[255:252];
         3'd2:    return frame[243:240];
         3'd3:    return frame[247:244];
         3'd4:    return frame[235:232];
         3'd5:    return frame[239:236];
         3'd6:    return frame[227:224];
         default: return MUX_IDLE_NIBBLE;
      endcase
   endfunction

   function automatic logic [31:0] slot_data(input mux_frame_t frame, input logic [2:0] i);
      case (i)
         3'd0:    return frame[223:192];
         3'd1:    return frame[191:160];
         3'd2:    return frame[159:128];
         3'd3:    return frame[127:96];
         3'd4:    return frame[95:64];
         3'd5:    return frame[63:32];
         3'd6:    return frame[31:0];
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/pcileech_demux_slotsel.sv
// Priority finder for the next non-idle slot; combinational, no backpressure.
// Only built with PCILEECH_DEMUX_IDLESKIP_EN defined.
`ifdef PCILEECH_DEMUX_IDLESKIP_EN
module pcileech_demux_slotsel
   import pcileech_mux_pkg::*;
(
   input  logic [MUX_SLOTS-1:0] mask,
   input  logic [2:0]           cur,
   input  logic                 incl,
   output logic [2:0]           nxt,
   output logic                 last
);

   // Descending scan so the lowest qualifying slot wins; incl also accepts cur itself.
   always_comb begin
      nxt  = cur;
      last = 1'b1;
      for (int i = MUX_SLOTS - 1; i >= 0; i--) begin
         if (mask[i] && ((3'(i) > cur) || (incl && (3'(i) == cur)))) begin
            nxt  = 3'(i);
            last = 1'b0;
         end
      end
   end

endmodule
`endif

// File: rtl/pcileech_demux.sv
// Unpacks 256-bit frames into per-tag 32-bit lanes, one slot per cycle, one cycle after accept.
// Head-of-line blocks on the current lane's ready; PCILEECH_DEMUX_IDLESKIP_EN skips idle slots.
module pcileech_demux
   import pcileech_mux_pkg::*;
#(
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [255:0]         din,
   input  logic                 din_valid,
   output logic                 din_ready,
   output logic [127:0]         dout,
   output logic [7:0]           dout_ctx,
   output logic [3:0]           dout_valid,
   input  logic [3:0]           dout_ready,
   output logic [ERR_CNT_W-1:0] err_count
);

   demux_state_t         state_q, state_d;
   mux_frame_t           frame_q, frame_d;
   logic [2:0]           slot_q, slot_d;
   logic [ERR_CNT_W-1:0] err_q, err_d;

   logic [3:0]  cur_nib;
   logic [1:0]  cur_tag;
   logic        cur_idle;
   logic [31:0] cur_data;
   logic        emit;
   logic        advance;
   logic        is_last;
   logic        last_consume;
   logic        accept;
   logic        din_good;
   logic        din_any;
   logic [2:0]  first_slot;
   logic [2:0]  next_slot;

   assign cur_nib  = slot_nibble(frame_q, slot_q);
   assign cur_tag  = cur_nib[1:0];
   assign cur_idle = (cur_nib == MUX_IDLE_NIBBLE);
   assign cur_data = slot_data(frame_q, slot_q);

   assign emit         = (state_q == ST_DRAIN) && !cur_idle;
   assign advance      = (state_q == ST_DRAIN) && (cur_idle || dout_ready[cur_tag]);
   assign last_consume = advance && is_last;
   assign din_ready    = rst_n && ((state_q == ST_EMPTY) || last_consume);
   assign accept       = din_valid && din_ready;
   assign din_good     = (frame_marker(din) == MUX_MARKER);

`ifdef PCILEECH_DEMUX_IDLESKIP_EN
   logic [MUX_SLOTS-1:0] mask_q;
   logic [MUX_SLOTS-1:0] mask_in;
   logic                 none_in;
   logic                 none_after;

   always_comb begin
      mask_q  = '0;
      mask_in = '0;
      for (int i = 0; i < MUX_SLOTS; i++) begin
         mask_q[i]  = (slot_nibble(frame_q, 3'(i)) != MUX_IDLE_NIBBLE);
         mask_in[i] = (slot_nibble(din, 3'(i)) != MUX_IDLE_NIBBLE);
      end
   end

   pcileech_demux_slotsel u_next (
      .mask (mask_q),
      .cur  (slot_q),
      .incl (1'b0),
      .nxt  (next_slot),
      .last (none_after)
   );

   pcileech_demux_slotsel u_first (
      .mask (mask_in),
      .cur  (3'd0),
      .incl (1'b1),
      .nxt  (first_slot),
      .last (none_in)
   );

   assign is_last = none_after;
   assign din_any = !none_in;
`else
   assign next_slot  = slot_q + 3'd1;
   assign is_last    = (slot_q == 3'(MUX_SLOTS - 1));
   assign first_slot = 3'd0;
   assign din_any    = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      slot_d  = slot_q;
      err_d   = err_q;
      if (accept) begin
         if (!din_good) begin
            state_d = ST_EMPTY;
            if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
         end else if (!din_any) begin
            // good frame with nothing to emit: consumed and dropped on the spot
            state_d = ST_EMPTY;
         end else begin
            state_d = ST_DRAIN;
            frame_d = din;
            slot_d  = first_slot;
         end
      end else if (advance) begin
         if (is_last) begin
            state_d = ST_EMPTY;
            slot_d  = 3'd0;
         end else begin
            slot_d = next_slot;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         frame_q <= '0;
         slot_q  <= 3'd0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         slot_q  <= slot_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      dout       = '0;
      dout_ctx   = '0;
      dout_valid = '0;
      for (int t = 0; t < 4; t++) begin
         if (emit && (cur_tag == 2'(t))) begin
            dout[32*t +: 32]  = cur_data;
            dout_ctx[2*t +: 2] = cur_nib[3:2];
            dout_valid[t]     = 1'b1;
         end
      end
   end

   assign err_count = err_q;

endmodule

// File: tb/tb_pcileech_demux.sv
// Directed bench for pcileech_demux with a word scoreboard checked at every lane handshake.
module tb_pcileech_demux;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [255:0] din;
   logic         din_valid;
   logic         din_ready;
   logic [127:0] dout;
   logic [7:0]   dout_ctx;
   logic [3:0]   dout_valid;
   logic [3:0]   dout_ready;
   logic [15:0]  err_count;

   int n_chk  = 0;
   int n_pass = 0;
   logic [35:0] sb[$];

   always #5 clk = ~clk;

   pcileech_demux #(.ERR_CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_ctx   (dout_ctx),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .err_count  (err_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // nibs holds slot i in nibs[4i+3:4i]; data is base+i, idle slots carry all-ones.
   function automatic logic [255:0] mk_frame(input logic [27:0] nibs, input logic [31:0] base,
                                             input logic [3:0] marker);
      logic [255:0] f;
      logic [3:0]   n;
      f = '0;
      for (int i = 0; i < 7; i++) begin
         n = nibs[4*i +: 4];
         f[223-32*i -: 32] = (n == 4'hF) ? 32'hFFFF_FFFF : base + 32'(i);
      end
      f[251:248] = nibs[3:0];
      f[255:252] = nibs[7:4];
      f[243:240] = nibs[11:8];
      f[247:244] = nibs[15:12];
      f[235:232] = nibs[19:16];
      f[239:236] = nibs[23:20];
      f[227:224] = nibs[27:24];
      f[231:228] = marker;
      return f;
   endfunction

   // Called a little after a rising edge; returns 1 time unit after the accepting edge.
   task automatic send(input logic [27:0] nibs, input logic [31:0] base, input logic [3:0] marker);
      logic [255:0] f;
      logic [3:0]   n;
      int           w;
      f = mk_frame(nibs, base, marker);
      if (marker == 4'hE) begin
         for (int i = 0; i < 7; i++) begin
            n = nibs[4*i +: 4];
            if (n != 4'hF) sb.push_back({n[1:0], n[3:2], f[223-32*i -: 32]});
         end
      end
      din       = f;
      din_valid = 1'b1;
      w         = 0;
      while (!din_ready && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("accept_wait", 64'(w < 100), 64'd1);
      @(posedge clk);
      #1;
      din_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 60) begin
         @(negedge clk);
         w++;
      end
      check("drain", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Every lane handshake must match the head of the scoreboard; an empty board forces a miss.
   always @(negedge clk) begin
      logic [35:0] got;
      logic [35:0] exp;
      if (dout_valid != 4'b0) check("onehot", 64'($onehot(dout_valid)), 64'd1);
      for (int t = 0; t < 4; t++) begin
         if (dout_valid[t] && dout_ready[t]) begin
            got = {2'(t), dout_ctx[2*t +: 2], dout[32*t +: 32]};
            if (sb.size() == 0) exp = ~got;
            else exp = sb.pop_front();
            check("word", 64'(got), 64'(exp));
         end
      end
   end

   initial begin
      int cnt;
      int exp_cycles;
      rst_n      = 1'b1;
      din        = '0;
      din_valid  = 1'b0;
      dout_ready = 4'hF;

      #1 rst_n = 1'b0;
      #1;
      check("rst_valid", 64'(dout_valid), 64'd0);
      check("rst_din_ready", 64'(din_ready), 64'd0);
      check("rst_err", 64'(err_count), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("post_rst_din_ready", 64'(din_ready), 64'd1);

      // all slots tag 1 ctx 0: lane 1 for 7 cycles, din_ready on the 7th
      send(28'h1111111, 32'h10, 4'hE);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         check("lane1_valid", 64'(dout_valid), 64'b0010);
         check("lane1_din_ready", 64'(din_ready), 64'(k == 7));
      end
      wait_drain();

      // tags 0,1,2,3,0,1,2 with ctx 2
      send(28'hA98BA98, 32'h200, 4'hE);
      wait_drain();

      // bad marker then saturation
      check("err_before", 64'(err_count), 64'd0);
      send(28'h1111111, 32'h300, 4'hD);
      check("err_one", 64'(err_count), 64'd1);
      repeat (3) begin
         @(negedge clk);
         check("bad_no_valid", 64'(dout_valid), 64'd0);
      end
      @(posedge clk);
      #1;
      din       = mk_frame(28'h1111111, 32'h310, 4'hD);
      din_valid = 1'b1;
      repeat (65538) @(posedge clk);
      #1 din_valid = 1'b0;
      check("err_sat", 64'(err_count), 64'hFFFF);
      check("err_sat_din_ready", 64'(din_ready), 64'd1);

      // lane 2 stalled under slot 3 (tags 0,1,3,2,0,1,3 ctx 1)
      dout_ready = 4'b1011;
      send(28'h7546754, 32'h400, 4'hE);
      cnt = 0;
      while (dout_valid != 4'b0100 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check("bp_reach", 64'(dout_valid), 64'b0100);
      repeat (5) begin
         @(negedge clk);
         check("bp_hold_valid", 64'(dout_valid), 64'b0100);
         check("bp_hold_data", 64'(dout[95:64]), 64'h403);
         check("bp_din_ready", 64'(din_ready), 64'd0);
      end
      @(posedge clk);
      #1 dout_ready = 4'hF;
      wait_drain();

      // slots 1 and 4 idle
`ifdef PCILEECH_DEMUX_IDLESKIP_EN
      exp_cycles = 5;
`else
      exp_cycles = 7;
`endif
      send(28'h11F11F1, 32'h500, 4'hE);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!din_ready && cnt < 20);
      check("idle_cycles", 64'(cnt), 64'(exp_cycles));
      wait_drain();

      // all-idle good frame
      send(28'hFFFFFFF, 32'h600, 4'hE);
`ifdef PCILEECH_DEMUX_IDLESKIP_EN
      check("allidle_valid", 64'(dout_valid), 64'd0);
      check("allidle_din_ready", 64'(din_ready), 64'd1);
`else
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!din_ready && cnt < 20);
      check("allidle_cycles", 64'(cnt), 64'd7);
`endif
      wait_drain();

      // reset while slot 3 is presented
      send(28'h0000000, 32'h700, 4'hE);
      repeat (3) @(posedge clk);
      #1;
      check("mid_valid", 64'(dout_valid), 64'b0001);
      check("mid_data", 64'(dout[31:0]), 64'h703);
      #1 rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(dout_valid), 64'd0);
      check("arst_din_ready", 64'(din_ready), 64'd0);
      check("arst_err", 64'(err_count), 64'd0);
      sb.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("rel_din_ready", 64'(din_ready), 64'd1);
      check("rel_err", 64'(err_count), 64'd0);
      send(28'h2103210, 32'h800, 4'hE);
      @(negedge clk);
      check("restart_valid", 64'(dout_valid), 64'b0001);
      check("restart_data", 64'(dout[31:0]), 64'h800);
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
